// File: rtl/bus_perf_pkg.sv
// Shared register map, control-bit positions and counter indices for the bus performance monitor.
package bus_perf_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'd0;
    localparam logic [3:0] OFF_CYC_LO = 4'd1;
    localparam logic [3:0] OFF_CYC_HI = 4'd2;
    localparam logic [3:0] OFF_RD_LO  = 4'd3;
    localparam logic [3:0] OFF_RD_HI  = 4'd4;
    localparam logic [3:0] OFF_WR_LO  = 4'd5;
    localparam logic [3:0] OFF_WR_HI  = 4'd6;
    localparam logic [3:0] OFF_INS_LO = 4'd7;
    localparam logic [3:0] OFF_INS_HI = 4'd8;
    localparam logic [3:0] OFF_STATUS = 4'd9;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_CLR_BIT = 1;

    localparam int unsigned NUM_REGS = 10;
    localparam int unsigned NUM_CNT  = 4;

    typedef enum logic [1:0] {
        CNT_CYC = 2'd0,
        CNT_RD  = 2'd1,
        CNT_WR  = 2'd2,
        CNT_INS = 2'd3
    } cnt_idx_e;

endpackage

// File: rtl/bus_perf_monitor_counter.sv
// Free-running event counter with synchronous clear and a sticky wrap-around flag.
module perf_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    logic [WIDTH-1:0] value_r;
    logic             ovf_r;

    // Count state; clear wins over an increment on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_r <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
        end else if (clr) begin
            value_r <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
        end else if (inc) begin
            value_r <= value_r + {{(WIDTH-1){1'b0}}, 1'b1};
            if (&value_r) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign value = value_r;
    assign ovf   = ovf_r;

endmodule

// File: rtl/bus_perf_monitor.sv
// Bus-slave performance monitor: counts cycles, foreign bus reads/writes and retired
// instructions, with HI-half shadows captured on LO reads for consistent 32-bit readout.
module bus_perf_monitor
    import bus_perf_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH    = 20,
    parameter int unsigned            DATA_WIDTH    = 16,
    parameter int unsigned            PC_WIDTH      = 10,
    parameter logic [ADDR_WIDTH-1:0]  START_ADDRESS = 20'h00400
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  bus_addr,
    inout  wire  [DATA_WIDTH-1:0]  bus_data,
    input  logic                   read,
    input  logic                   write,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   halted
);

    localparam int unsigned           CW      = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] WIN_LEN = ADDR_WIDTH'(NUM_REGS);

    logic [ADDR_WIDTH-1:0] rel_s;
    logic [3:0]            off_s;
    logic                  sel_s;
    logic                  ctrl_wr_s;
    logic                  clr_s;
    logic                  count_s;
    logic [NUM_CNT-1:0]    inc_s;
    logic [NUM_CNT-1:0]    ovf_s;
    logic [CW-1:0]         cnt_s [NUM_CNT];
    logic [DATA_WIDTH-1:0] rdata_s;

    logic                  en_r;
    logic [PC_WIDTH-1:0]   last_pc_r;
    logic [DATA_WIDTH-1:0] hi_r [NUM_CNT];

    assign rel_s     = bus_addr - START_ADDRESS;
    assign off_s     = rel_s[3:0];
    assign sel_s     = (bus_addr >= START_ADDRESS) && (rel_s < WIN_LEN);
    assign ctrl_wr_s = write && sel_s && (off_s == OFF_CTRL);
    assign clr_s     = ctrl_wr_s && bus_data[CTRL_CLR_BIT];
    assign count_s   = en_r && !halted;

    // Own-window accesses are excluded so software polling does not skew its statistics
    assign inc_s[CNT_CYC] = count_s;
    assign inc_s[CNT_RD]  = count_s && read && !sel_s;
    assign inc_s[CNT_WR]  = count_s && write && !sel_s;
    assign inc_s[CNT_INS] = count_s && (pc != last_pc_r);

    perf_counter #(.WIDTH(CW)) u_cnt_cyc (
        .clk(clk), .reset(reset), .clr(clr_s), .inc(inc_s[CNT_CYC]),
        .value(cnt_s[CNT_CYC]), .ovf(ovf_s[CNT_CYC])
    );
    perf_counter #(.WIDTH(CW)) u_cnt_rd (
        .clk(clk), .reset(reset), .clr(clr_s), .inc(inc_s[CNT_RD]),
        .value(cnt_s[CNT_RD]), .ovf(ovf_s[CNT_RD])
    );
    perf_counter #(.WIDTH(CW)) u_cnt_wr (
        .clk(clk), .reset(reset), .clr(clr_s), .inc(inc_s[CNT_WR]),
        .value(cnt_s[CNT_WR]), .ovf(ovf_s[CNT_WR])
    );
    perf_counter #(.WIDTH(CW)) u_cnt_ins (
        .clk(clk), .reset(reset), .clr(clr_s), .inc(inc_s[CNT_INS]),
        .value(cnt_s[CNT_INS]), .ovf(ovf_s[CNT_INS])
    );

    // Enable bit and pc history; pc tracks even while disabled so re-enable adds no phantom instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r      <= 1'b1;
            last_pc_r <= {PC_WIDTH{1'b1}};
        end else begin
            last_pc_r <= pc;
            if (ctrl_wr_s) begin
                en_r <= bus_data[CTRL_EN_BIT];
            end
        end
    end

    // HI shadows latch the upper half at the edge ending a LO read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                hi_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (clr_s) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                hi_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (read && sel_s) begin
            case (off_s)
                OFF_CYC_LO: hi_r[CNT_CYC] <= cnt_s[CNT_CYC][CW-1:DATA_WIDTH];
                OFF_RD_LO:  hi_r[CNT_RD]  <= cnt_s[CNT_RD][CW-1:DATA_WIDTH];
                OFF_WR_LO:  hi_r[CNT_WR]  <= cnt_s[CNT_WR][CW-1:DATA_WIDTH];
                OFF_INS_LO: hi_r[CNT_INS] <= cnt_s[CNT_INS][CW-1:DATA_WIDTH];
                default: ;
            endcase
        end
    end

    // Register read mux
    always_comb begin
        rdata_s = {DATA_WIDTH{1'b0}};
        case (off_s)
            OFF_CTRL:   rdata_s[CTRL_EN_BIT] = en_r;
            OFF_CYC_LO: rdata_s = cnt_s[CNT_CYC][DATA_WIDTH-1:0];
            OFF_CYC_HI: rdata_s = hi_r[CNT_CYC];
            OFF_RD_LO:  rdata_s = cnt_s[CNT_RD][DATA_WIDTH-1:0];
            OFF_RD_HI:  rdata_s = hi_r[CNT_RD];
            OFF_WR_LO:  rdata_s = cnt_s[CNT_WR][DATA_WIDTH-1:0];
            OFF_WR_HI:  rdata_s = hi_r[CNT_WR];
            OFF_INS_LO: rdata_s = cnt_s[CNT_INS][DATA_WIDTH-1:0];
            OFF_INS_HI: rdata_s = hi_r[CNT_INS];
            OFF_STATUS: rdata_s = {{(DATA_WIDTH-5){1'b0}}, halted, ovf_s};
            default:    rdata_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Same-cycle read data like data_memory; released immediately under reset
    assign bus_data = (read && sel_s && !reset) ? rdata_s : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_perf_monitor.sv
// Directed scoreboard bench for bus_perf_monitor: stimulus queues expected read data,
// a negedge monitor checks every selected read and that the bus floats otherwise.
module tb_bus_perf_monitor;

    localparam logic [19:0] BASE = 20'h00400;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] bus_addr;
    logic        read;
    logic        write;
    logic [9:0]  pc;
    logic        halted;
    logic [15:0] drv_data;
    logic        drv_en;
    wire  [15:0] bus_data;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    assign bus_data = drv_en ? drv_data : 16'hzzzz;

    // Floating bus reads as all ones
    for (genvar g = 0; g < 16; g++) begin : g_pull
        pullup pu (bus_data[g]);
    end

    bus_perf_monitor dut (
        .clk      (clk),
        .reset    (reset),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .read     (read),
        .write    (write),
        .pc       (pc),
        .halted   (halted)
    );

    function automatic bit in_window(input logic [19:0] a);
        return (a >= BASE) && (a <= BASE + 20'd9);
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: selected reads pop the scoreboard, every other idle cycle expects a floating bus
    always @(negedge clk) begin
        if (read && in_window(bus_addr) && !reset) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: addr %h data %h with empty scoreboard", bus_addr, bus_data);
            end else begin
                mon_e = sb_q.pop_front();
                check(mon_e.name, bus_data, mon_e.exp);
            end
        end else if (!drv_en) begin
            check("bus_float", bus_data, 16'hFFFF);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] off, input string nm, input logic [15:0] exp);
        bus_addr = BASE + {16'h0000, off};
        read     = 1'b1;
        sb_q.push_back('{name: nm, exp: exp});
        tick();
        read     = 1'b0;
    endtask

    task automatic rd_ext(input logic [19:0] a);
        bus_addr = a;
        read     = 1'b1;
        tick();
        read     = 1'b0;
    endtask

    task automatic wr(input logic [19:0] a, input logic [15:0] d);
        bus_addr = a;
        drv_data = d;
        drv_en   = 1'b1;
        write    = 1'b1;
        tick();
        write    = 1'b0;
        drv_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0; bus_addr = 20'h00000;
        pc = 10'd0; halted = 1'b0; drv_data = 16'h0000; drv_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // 10 cycles, pc changes every cycle, no strobes
        for (int i = 1; i <= 10; i++) begin
            pc = 10'(i);
            tick();
        end
        rd(4'd1, "cyc_lo_after_10", 16'd10);
        rd(4'd7, "ins_lo_after_10", 16'd10);
        rd(4'd3, "rd_lo_idle", 16'd0);
        rd(4'd5, "wr_lo_idle", 16'd0);
        rd(4'd0, "ctrl_reset", 16'h0001);
        rd(4'd9, "status_reset", 16'h0000);

        // foreign reads/writes counted, own-window read excluded
        for (int i = 0; i < 3; i++) rd_ext(20'h00010);
        for (int i = 0; i < 2; i++) wr(20'h00020, 16'hBEEF);
        rd(4'd3, "rd_lo_three", 16'h0003);
        rd(4'd5, "wr_lo_two", 16'h0002);

        // clear, disable for 5 cycles while pc moves, re-enable with pc steady
        wr(BASE, 16'h0003);
        wr(BASE, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            pc = 10'(20 + i);
            tick();
        end
        wr(BASE, 16'h0001);
        rd(4'd1, "cyc_frozen", 16'd1);
        rd(4'd7, "ins_no_jump", 16'd0);
        rd(4'd1, "cyc_resumed", 16'd3);
        rd(4'd0, "ctrl_en_back", 16'h0001);

        // HI shadow captured on the LO read edge
        dut.u_cnt_cyc.value_r = 32'h0001_FFFF;
        rd(4'd1, "cyc_lo_pre_carry", 16'hFFFF);
        repeat (3) tick();
        rd(4'd2, "cyc_hi_shadow", 16'h0001);
        rd(4'd9, "status_no_ovf", 16'h0000);
        rd(4'd1, "cyc_lo_later", 16'h0005);
        rd(4'd2, "cyc_hi_reshadow", 16'h0002);

        // wrap sets sticky overflow; CLR beats the same-edge increment
        dut.u_cnt_cyc.value_r = 32'hFFFF_FFFF;
        tick();
        rd(4'd1, "cyc_wrapped", 16'h0000);
        rd(4'd9, "status_ovf", 16'h0001);
        wr(BASE, 16'h0003);
        rd(4'd1, "cyc_after_clr", 16'h0000);
        rd(4'd9, "status_after_clr", 16'h0000);
        rd(4'd0, "ctrl_after_clr", 16'h0001);
        rd(4'd3, "rd_after_clr", 16'h0000);
        rd(4'd5, "wr_after_clr", 16'h0000);
        rd(4'd2, "cyc_hi_after_clr", 16'h0000);

        // halted freezes counting while strobes and pc keep moving
        halted = 1'b1;
        pc = 10'd30; rd_ext(20'h00010);
        pc = 10'd31; wr(20'h00020, 16'h1234);
        pc = 10'd32; rd_ext(20'h00010);
        pc = 10'd33; wr(20'h00020, 16'h5678);
        rd(4'd9, "status_halted", 16'h0010);
        rd(4'd1, "cyc_halted", 16'd6);
        rd(4'd3, "rd_halted", 16'd0);
        rd(4'd5, "wr_halted", 16'd0);
        rd(4'd7, "ins_halted", 16'd0);
        halted = 1'b0;
        rd(4'd1, "cyc_unhalted", 16'd6);
        rd(4'd7, "ins_unhalted", 16'd0);

        // reset pulse in the middle of a CTRL read
        bus_addr = BASE;
        read = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("reset_releases_bus", bus_data, 16'hFFFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.push_back('{name: "ctrl_after_reset", exp: 16'h0001});
        tick();
        read = 1'b0;
        rd(4'd1, "cyc_after_reset", 16'd1);
        rd(4'd7, "ins_after_reset", 16'd1);
        rd(4'd9, "status_after_reset", 16'h0000);

        tick();
        check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_perf_monitor.md
Name: bus_perf_monitor

Overview:
- Memory-mapped performance monitor on the shared CPU bus, alongside data_memory; a bus slave.
- Snoops the bus strobes plus cpu pc/halted and counts cycles, data-memory reads, writes and retired instructions.
- Counters follow the same rules the system bench applies, so software running on the cpu can read its own statistics over the bus.
- Readout is snapshot-consistent.

Parameters:
- START_ADDRESS, 20'h00400: base word address of the register window (directly above 1024-word data memory).
- ADDR_WIDTH, 20: bus address width.
- DATA_WIDTH, 16: bus data width. Counters are 2*DATA_WIDTH bits.
- PC_WIDTH, 10: cpu pc width.

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-high reset.
- bus_addr  in  ADDR_WIDTH  bus word address.
- bus_data  inout  DATA_WIDTH  shared bus data. Driven only on a selected read, high-Z otherwise.
- read  in  1  bus read strobe.
- write  in  1  bus write strobe.
- pc  in  PC_WIDTH  cpu program counter.
- halted  in  1  cpu halted flag.

Behaviour:
- Select: sel = bus_addr in [START_ADDRESS, START_ADDRESS+9].
- Register map (word offsets):
  - 0 CTRL: bit0 EN (R/W), bit1 CLR (write-only, reads 0).
  - 1/2 CYC_LO/HI.
  - 3/4 RD_LO/HI.
  - 5/6 WR_LO/HI.
  - 7/8 INS_LO/HI.
  - 9 STATUS: bits3:0 sticky overflow for CYC, RD, WR, INS; bit4 = halted. Read-only.
- Read timing:
  - bus_data = register value combinationally while read && sel, same cycle, matching data_memory read timing.
  - Otherwise 'z.
  - read && !sel is ignored.
- Write timing:
  - Captured at posedge clk when write && sel.
  - Writes to any offset other than 0 are ignored.
  - Writing CTRL with bit1=1 zeroes all four counters, all overflow bits and all shadows at that edge. EN takes the written bit0 at the same edge.
- Snapshot:
  - At posedge, read && sel && offset in {1,3,5,7}: copy that counter's current upper half into its HI shadow.
  - HI offsets return the shadow, not the live counter.
  - Shadows reset to 0.
- Counting, at each posedge with EN=1 and halted=0:
  - CYC += 1.
  - RD += 1 if read && !sel.
  - WR += 1 if write && !sel.
  - INS += 1 if pc != last_pc.
  - last_pc <= pc every posedge regardless of EN, so re-enabling does not fake an instruction.
  - Accesses to the monitor's own window are never counted.
- halted=1 freezes all counters. Register access still works.
- Wrap-around: a counter at 32'hFFFF_FFFF increments to 0 and sets its sticky overflow bit. Only reset or CLR clears overflow bits.
- Priority: CLR beats a same-edge increment; the counter is 0 after that edge.
- Reset (async, any time, including mid-access):
  - Counters, shadows and overflow bits = 0.
  - EN = 1, so counting starts at the first edge after reset, as in the bench.
  - last_pc = all ones.
  - bus_data = 'z.
- No wait states, no internal FSM beyond the registers listed. Each counter is a 32-bit register with inc/clear/overflow.

Decomposition:
- Package bus_perf_pkg:
  - Offset localparams (OFF_CTRL..OFF_STATUS).
  - CTRL bit indices.
  - NUM_REGS = 10.
  - Counter-index enum {CNT_CYC, CNT_RD, CNT_WR, CNT_INS}.
- Sub-module perf_counter:
  - Ports: clk, reset, clr, inc, value[31:0], ovf.
  - Instantiated 4x.
- Read mux, snapshot shadows and CTRL live in the top level.

Test Plan:
- Reset, then 10 cycles with pc changing each cycle, no strobes, halted=0 → CYC_LO=10, INS_LO=10, RD_LO=0, WR_LO=0; bus_data 'z whenever not read-selected.
- 3 reads at 20'h00010 and 2 writes at 20'h00020, then 1 read of base+3 → RD=3 (the monitor read is excluded), WR=2, bus_data on the read = 16'h0003.
- Write CTRL=16'h0000, run 5 cycles, write CTRL=16'h0001 → CYC frozen across those 5 cycles; INS does not jump on re-enable with unchanged pc.
- Force CYC to 32'h0001_FFFF via hierarchical deposit; read CYC_LO, then 3 cycles later read CYC_HI → returns shadowed 16'h0001 (or 16'h0002 if the LO read saw the wrap edge; check against the model); STATUS bit0 = 0.
- Force CYC = 32'hFFFF_FFFF, one cycle → CYC = 0, STATUS = 16'h0001. Then write CTRL=16'h0003 on the same edge as an increment → all counters 0, STATUS = 0, EN = 1.
- Assert halted=1 with strobes active for 4 cycles → no counter changes; STATUS bit4 = 1. Pulse reset mid-read → bus_data goes 'z immediately, CTRL reads 16'h0001.
